// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver sampled in the clk domain: synchronised and glitch-filtered
// SCL, start/parity/stop checking, and a first-word-fall-through receive FIFO.
module ps2_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_ODD  = 1,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            SCL,
  input  logic                            SDA,
  output logic [DATA_BITS-1:0]            data_out,
  output logic                            data_valid,
  input  logic                            data_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);
  localparam logic [3:0]    FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  logic [1:0]           scl_sync_reg, sda_sync_reg;
  logic                 scl_s, sda_s;
  logic                 fscl_reg;
  logic [3:0]           filt_cnt_reg;
  logic                 sample_evt;
  state_t               state_reg, state_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next;
  logic                 par_bit_reg, par_bit_next;
  logic [TW-1:0]        to_cnt_reg;
  logic                 timeout, par_ok;
  logic                 push_req, perr_next, ferr_next;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 full, pop, push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], SCL};
      sda_sync_reg <= {sda_sync_reg[0], SDA};
    end
  end

  assign scl_s = scl_sync_reg[1];
  assign sda_s = sda_sync_reg[1];

  // fscl follows scl_s only after FILT_LEN consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      fscl_reg     <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (scl_s == fscl_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_cnt_reg == FILT_MAX) begin
      fscl_reg     <= scl_s;
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 4'd1;
    end
  end

  assign sample_evt = fscl_reg && !scl_s && (filt_cnt_reg == FILT_MAX);
  assign timeout    = (state_reg != IDLE) && (to_cnt_reg == TO_MAX);
  assign par_ok     = (PARITY_EN == 0) || ((^shreg_reg ^ par_bit_reg) == 1'(PARITY_ODD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
      par_bit_reg <= 1'b0;
      to_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      par_bit_reg <= par_bit_next;
      if (state_reg == IDLE || sample_evt || timeout)
        to_cnt_reg <= '0;
      else
        to_cnt_reg <= to_cnt_reg + TW'(1);
    end
  end

  // Timeout takes priority over a coincident sample event
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    par_bit_next = par_bit_reg;
    push_req     = 1'b0;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;
    if (timeout) begin
      state_next = IDLE;
      ferr_next  = 1'b1;
    end else if (sample_evt) begin
      case (state_reg)
        IDLE: begin
          if (!sda_s) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shreg_next   = {sda_s, shreg_reg[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt_reg + BW'(1);
          if (bit_cnt_reg == BIT_LAST)
            state_next = (PARITY_EN != 0) ? PAR : STOP;
        end
        PAR: begin
          par_bit_next = sda_s;
          state_next   = STOP;
        end
        STOP: begin
          if (!sda_s)
            ferr_next = 1'b1;
          else if (!par_ok)
            perr_next = 1'b1;
          else
            push_req = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign data_valid = (count_reg != '0);
  assign full       = (count_reg == DEPTH_C);
  assign pop        = data_valid && data_ready;
  assign push_ok    = push_req && (!full || pop);
  assign data_out   = data_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_count = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= shreg_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      parity_err <= perr_next;
      frame_err  <= ferr_next;
      overflow   <= push_req && full && !pop;
    end
  end

endmodule
